// File: rtl/exmem_stage.sv
// exmem_stage: EX/MEM pipeline register with NVZ flag register and a data-memory request FSM.
module exmem_stage #(
   parameter int DW     = 16,
   parameter int NFLAGS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DW-1:0]     ex_inst,
   input  logic [DW-1:0]     ex_pc,
   input  logic [DW-1:0]     ex_alu,
   input  logic [DW-1:0]     ex_store,
   input  logic              ex_is_load,
   input  logic              ex_is_store,
   input  logic [NFLAGS-1:0] ex_nvz,
   input  logic [NFLAGS-1:0] ex_nvz_we,
   input  logic              mem_ready,
   output logic [DW-1:0]     inst_pl,
   output logic [DW-1:0]     pc_pl,
   output logic [DW-1:0]     alu_pl,
   output logic [DW-1:0]     store_pl,
   output logic              valid_pl,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [NFLAGS-1:0] nvz,
   output logic              stall_out
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_nx;
   logic busy, capture, retire, op_ld, op_st;

   always_ff @(posedge clk)
      state <= !rst ? IDLE : state_nx;

   always_comb begin
      busy     = (state == REQ) & ~mem_ready;
      capture  = write & ~busy;
      retire   = capture & ex_valid & ~flush;
      state_nx = (busy | (retire & (ex_is_load | ex_is_store))) ? REQ : IDLE;
   end

   // request strobes come only from registered state, never from ex_* inputs
   assign mem_rd    = (state == REQ) & op_ld;
   assign mem_wr    = (state == REQ) & op_st;
   assign stall_out = busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_pl  <= '0;
         pc_pl    <= '0;
         alu_pl   <= '0;
         store_pl <= '0;
         valid_pl <= 1'b0;
         op_ld    <= 1'b0;
         op_st    <= 1'b0;
         nvz      <= '0;
      end else begin
         if (capture) begin
            inst_pl  <= flush ? '0 : ex_inst;
            pc_pl    <= flush ? '0 : ex_pc;
            alu_pl   <= ex_alu;
            store_pl <= ex_store;
            valid_pl <= ex_valid & ~flush;
            op_ld    <= ex_is_load;
            op_st    <= ex_is_store;
         end
         if (retire)
            nvz <= (ex_nvz & ex_nvz_we) | (nvz & ~ex_nvz_we);
      end
   end
endmodule
